// File: rtl/aes_test_sequencer.sv
// Purpose: run controller for the AES platform; turns UART command bytes into datapath work/enc.
// Latency: all outputs registered; a command takes effect on the edge that samples cmd_valid.
// Backpressure: none; every strobed byte is consumed; the datapath is throttled only by work.
module aes_test_sequencer #(
    parameter int BATCH      = 1000,
    parameter int GAP_CYCLES = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] total,
    output logic             work,
    output logic             enc,
    output logic             busy,
    output logic             auto_mode,
    output logic             phase_done
);

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Command bytes
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_A = 8'h41;
    localparam logic [7:0] CMD_S = 8'h53;

    // Gap counter loads GAP_CYCLES-1 on entry and leaves GAP on the edge after it reaches zero,
    // which keeps work low for exactly GAP_CYCLES cycles.
    localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BATCH_CNT = CNT_W'(BATCH);

    // Registered state
    logic [1:0]       state;
    logic             run_dir;
    logic             run_auto;
    logic             pend_stop;
    logic             pend_auto;
    logic             pend_dir;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] base;

    // Next-state values
    logic [1:0]       state_nxt;
    logic             work_nxt;
    logic             enc_nxt;
    logic             busy_nxt;
    logic             auto_mode_nxt;
    logic             phase_done_nxt;
    logic             run_dir_nxt;
    logic             run_auto_nxt;
    logic             pend_stop_nxt;
    logic             pend_auto_nxt;
    logic             pend_dir_nxt;
    logic [GAP_W-1:0] gap_cnt_nxt;
    logic [CNT_W-1:0] base_nxt;

    // Command decode
    logic cmd_e;
    logic cmd_d;
    logic cmd_a;
    logic cmd_s;
    logic cmd_any;
    logic cmd_start;
    logic cmd_dir;
    logic cmd_same;
    logic cmd_switch;

    assign cmd_e     = cmd_valid && (cmd_data == CMD_E);
    assign cmd_d     = cmd_valid && (cmd_data == CMD_D);
    assign cmd_a     = cmd_valid && (cmd_data == CMD_A);
    assign cmd_s     = cmd_valid && (cmd_data == CMD_S);
    assign cmd_any   = cmd_e | cmd_d | cmd_a | cmd_s;
    assign cmd_start = cmd_e | cmd_d | cmd_a;
    // Auto mode always opens with encrypt; 'S' carries no direction.
    assign cmd_dir   = cmd_e | cmd_a;

    // A command repeating the current mode is a no-op while running.
    assign cmd_same   = (cmd_e && !run_auto &&  run_dir) ||
                        (cmd_d && !run_auto && !run_dir) ||
                        (cmd_a &&  run_auto);
    assign cmd_switch = cmd_any && !cmd_same;

    // Batch progress; modular subtraction makes a wrap of total transparent.
    logic [CNT_W-1:0] batch_cnt;
    logic             batch_end;

    assign batch_cnt = total - base;
    assign batch_end = run_auto && (batch_cnt >= BATCH_CNT);

    // Pending seen by the gap: a command arriving this cycle replaces the stored one.
    logic eff_stop;
    logic eff_auto;
    logic eff_dir;

    assign eff_stop = cmd_any ? cmd_s   : pend_stop;
    assign eff_auto = cmd_any ? cmd_a   : pend_auto;
    assign eff_dir  = cmd_any ? cmd_dir : pend_dir;

    // Next-state and output decisions for the IDLE/RUN/GAP controller
    always_comb begin
        state_nxt      = state;
        work_nxt       = work;
        enc_nxt        = enc;
        busy_nxt       = busy;
        auto_mode_nxt  = auto_mode;
        phase_done_nxt = 1'b0;
        run_dir_nxt    = run_dir;
        run_auto_nxt   = run_auto;
        pend_stop_nxt  = pend_stop;
        pend_auto_nxt  = pend_auto;
        pend_dir_nxt   = pend_dir;
        gap_cnt_nxt    = gap_cnt;
        base_nxt       = base;

        case (state)
            ST_IDLE: begin
                // No drain needed from idle: the datapath is already stopped.
                if (cmd_start) begin
                    state_nxt     = ST_RUN;
                    work_nxt      = 1'b1;
                    busy_nxt      = 1'b1;
                    enc_nxt       = cmd_dir;
                    run_dir_nxt   = cmd_dir;
                    run_auto_nxt  = cmd_a;
                    auto_mode_nxt = cmd_a;
                    base_nxt      = total;
                end
            end

            ST_RUN: begin
                // The batch pulse fires even when a command pre-empts the auto turnaround.
                phase_done_nxt = batch_end;
                if (cmd_switch || batch_end) begin
                    state_nxt   = ST_GAP;
                    work_nxt    = 1'b0;
                    gap_cnt_nxt = GAP_LOAD;
                    if (cmd_switch) begin
                        pend_stop_nxt = cmd_s;
                        pend_auto_nxt = cmd_a;
                        pend_dir_nxt  = cmd_dir;
                    end else begin
                        pend_stop_nxt = 1'b0;
                        pend_auto_nxt = 1'b1;
                        pend_dir_nxt  = ~run_dir;
                    end
                end
            end

            ST_GAP: begin
                // enc is left alone here so it only ever changes while work is low
                // and becomes visible together with the rising work.
                if (gap_cnt == '0) begin
                    if (eff_stop) begin
                        state_nxt     = ST_IDLE;
                        busy_nxt      = 1'b0;
                        auto_mode_nxt = 1'b0;
                        run_auto_nxt  = 1'b0;
                    end else begin
                        state_nxt     = ST_RUN;
                        work_nxt      = 1'b1;
                        enc_nxt       = eff_dir;
                        run_dir_nxt   = eff_dir;
                        run_auto_nxt  = eff_auto;
                        auto_mode_nxt = eff_auto;
                        base_nxt      = total;
                    end
                    pend_stop_nxt = 1'b0;
                    pend_auto_nxt = 1'b0;
                    pend_dir_nxt  = 1'b0;
                end else begin
                    gap_cnt_nxt   = gap_cnt - GAP_W'(1);
                    pend_stop_nxt = eff_stop;
                    pend_auto_nxt = eff_auto;
                    pend_dir_nxt  = eff_dir;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                work_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any run and pending command at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            work       <= 1'b0;
            enc        <= 1'b1;
            busy       <= 1'b0;
            auto_mode  <= 1'b0;
            phase_done <= 1'b0;
            run_dir    <= 1'b1;
            run_auto   <= 1'b0;
            pend_stop  <= 1'b0;
            pend_auto  <= 1'b0;
            pend_dir   <= 1'b0;
            gap_cnt    <= '0;
            base       <= '0;
        end else begin
            state      <= state_nxt;
            work       <= work_nxt;
            enc        <= enc_nxt;
            busy       <= busy_nxt;
            auto_mode  <= auto_mode_nxt;
            phase_done <= phase_done_nxt;
            run_dir    <= run_dir_nxt;
            run_auto   <= run_auto_nxt;
            pend_stop  <= pend_stop_nxt;
            pend_auto  <= pend_auto_nxt;
            pend_dir   <= pend_dir_nxt;
            gap_cnt    <= gap_cnt_nxt;
            base       <= base_nxt;
        end
    end

endmodule

// File: tb/tb_aes_test_sequencer.sv
// Purpose: directed bench for aes_test_sequencer (BATCH=4, GAP_CYCLES=64).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled there too.
// Backpressure: not applicable; commands are single-cycle strobes.
module tb_aes_test_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic [31:0] total = 32'h0;
    logic        work;
    logic        enc;
    logic        busy;
    logic        auto_mode;
    logic        phase_done;

    int errors = 0;
    int checks = 0;

    aes_test_sequencer #(
        .BATCH      (4),
        .GAP_CYCLES (64),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .total      (total),
        .work       (work),
        .enc        (enc),
        .busy       (busy),
        .auto_mode  (auto_mode),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {work, enc, busy, auto_mode, phase_done}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'h0, work, enc, busy, auto_mode, phase_done}, {27'h0, exp});
    endtask

    task automatic send(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    // Call right after the edge that dropped work; counts cycles with work low.
    task automatic measure_gap(output int n, output bit enc_moved, output bit pd_seen);
        logic e0;
        e0        = enc;
        n         = 1;
        enc_moved = 1'b0;
        pd_seen   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (work) break;
            n++;
            if (enc !== e0) enc_moved = 1'b1;
            if (phase_done) pd_seen = 1'b1;
        end
    endtask

    // Four increments of total, one every 10 cycles, flagging any early batch pulse.
    task automatic step_total4(output bit early);
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (10) begin
                tick;
                if (phase_done || !work) early = 1'b1;
            end
            total = total + 32'd1;
        end
    endtask

    int n;
    bit moved;
    bit pd_seen;
    bit early;
    bit work_seen;

    initial begin
        // Reset
        repeat (3) tick;
        chk_out("reset_values", 5'b01000);
        rst = 1'b0;
        repeat (6) tick;
        chk_out("idle_no_cmd", 5'b01000);

        // 1: encrypt run, repeated 'E' ignored
        send(8'h45);
        chk_out("t1_enc_run", 5'b11100);
        send(8'h45);
        tick;
        chk_out("t1_repeat_e", 5'b11100);

        // 2: switch to decrypt through a 64-cycle gap
        send(8'h44);
        chk_out("t2_gap_entry", 5'b01100);
        measure_gap(n, moved, pd_seen);
        chk("t2_gap_len", n, 64);
        chk("t2_enc_stable", {31'h0, moved}, 0);
        chk_out("t2_dec_run", 5'b10100);

        // 3: auto mode, BATCH=4, alternating phases
        send(8'h41);
        chk_out("t3_gap_entry", 5'b00100);
        measure_gap(n, moved, pd_seen);
        chk("t3_gap0_len", n, 64);
        chk_out("t3_auto_enc_run", 5'b11110);
        send(8'h41);
        chk_out("t3_repeat_a", 5'b11110);
        step_total4(early);
        tick;
        chk("t3_no_early_pd1", {31'h0, early}, 0);
        chk_out("t3_batch1_end", 5'b01111);
        measure_gap(n, moved, pd_seen);
        chk("t3_gap1_len", n, 64);
        chk("t3_pd_one_cycle", {31'h0, pd_seen}, 0);
        chk_out("t3_auto_dec_run", 5'b10110);
        step_total4(early);
        tick;
        chk("t3_no_early_pd2", {31'h0, early}, 0);
        chk_out("t3_batch2_end", 5'b00111);
        // Next run latches this value as its base
        total = 32'hFFFF_FFFE;
        measure_gap(n, moved, pd_seen);
        chk("t3_gap2_len", n, 64);
        chk_out("t3_auto_enc_again", 5'b11110);

        // 4: batch across the wrap of total
        total = 32'hFFFF_FFFF;
        repeat (3) tick;
        total = 32'h0000_0000;
        repeat (3) tick;
        total = 32'h0000_0001;
        repeat (3) tick;
        chk_out("t4_not_yet", 5'b11110);
        total = 32'h0000_0002;
        tick;
        chk_out("t4_wrap_end", 5'b01111);

        // 5: 'D' then 'S' during the gap; last one wins -> idle
        n = 1;
        work_seen = 1'b0;
        send(8'h44);
        n++;
        send(8'h53);
        n++;
        for (int i = 0; i < 200 && busy; i++) begin
            tick;
            if (busy) n++;
            if (work) work_seen = 1'b1;
        end
        chk("t5_gap_len", n, 64);
        chk("t5_no_work", {31'h0, work_seen}, 0);
        chk_out("t5_idle", 5'b01000);
        send(8'h7A);
        tick;
        chk_out("t5_ignore_7a", 5'b01000);
        send(8'h53);
        chk_out("t5_ignore_s_idle", 5'b01000);

        // 6: asynchronous reset in RUN and in GAP
        send(8'h44);
        chk_out("t6_dec_run", 5'b10100);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_rst_in_run", 5'b01000);
        tick;
        rst = 1'b0;
        send(8'h45);
        chk_out("t6_clean_run", 5'b11100);
        send(8'h41);
        chk_out("t6_gap_entry", 5'b01100);
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_rst_in_gap", 5'b01000);
        tick;
        rst = 1'b0;
        repeat (80) tick;
        chk_out("t6_pending_dropped", 5'b01000);
        send(8'h41);
        chk_out("t6_auto_from_idle", 5'b11110);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_rst_clears_auto", 5'b01000);
        tick;
        rst = 1'b0;
        send(8'h45);
        chk_out("t6_restart_enc", 5'b11100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
